// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the CPU instruction sequencer family.
// Holds opcodes, ALU function codes, RAM control levels and the FSM state encoding.
package cpu_seq_pkg;

    localparam int unsigned OPC_W     = 3;
    localparam int unsigned ALU_SEL_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_STO = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_NOT = 3'd6,
        OP_NOP = 3'd7
    } opcode_e;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_TRANSFER  = 4'h0,
        ALU_ADD_AB    = 4'h1,
        ALU_SUB_A_B_1 = 4'h2,
        ALU_AND_MASK  = 4'h3,
        ALU_OR_MASK   = 4'h4,
        ALU_XOR_MASK  = 4'h5,
        ALU_NOT_MASK  = 4'h6
    } alu_sel_e;

    // RAM control levels: chip select is active-low, rwn high means read
    localparam logic RAM_ACTIVE = 1'b0;
    localparam logic RAM_IDLE   = 1'b1;
    localparam logic RAM_READ   = 1'b1;
    localparam logic RAM_WRITE  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_e;

    function automatic logic is_nop(opcode_e op);
        return op == OP_NOP;
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction handshake plus RAM and ALU buses of the sequencer.
// master = sequencer side, slave = instruction source / RAM / ALU side.
interface exec_sequencer_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
);
    localparam int unsigned INSTR_W = 3 + ADDR_W + DATA_W;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic               done;
    logic               ram_csn;
    logic               ram_rwn;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_data_in;
    logic [DATA_W-1:0]  ram_data_out;
    logic               ram_ack;
    logic               alu_en;
    logic [3:0]         alu_sel;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_result;

    modport master (
        input  instr_valid, instr, ram_data_out, ram_ack, alu_result,
        output instr_ready, done, ram_csn, ram_rwn, ram_addr, ram_data_in,
               alu_en, alu_sel, alu_a, alu_b
    );

    modport slave (
        output instr_valid, instr, ram_data_out, ram_ack, alu_result,
        input  instr_ready, done, ram_csn, ram_rwn, ram_addr, ram_data_in,
               alu_en, alu_sel, alu_a, alu_b
    );

endinterface

// File: rtl/exec_sequencer_alu_map.sv
// Combinational opcode to ALU function code mapping (seq_alu_map).
module seq_alu_map
    import cpu_seq_pkg::*;
(
    input  opcode_e  opcode,
    output alu_sel_e alu_sel_c
);

    always_comb begin
        alu_sel_c = ALU_TRANSFER;
        unique case (opcode)
            OP_STO,
            OP_ADD:  alu_sel_c = ALU_ADD_AB;
            OP_SUB:  alu_sel_c = ALU_SUB_A_B_1;
            OP_AND:  alu_sel_c = ALU_AND_MASK;
            OP_OR:   alu_sel_c = ALU_OR_MASK;
            OP_XOR:  alu_sel_c = ALU_XOR_MASK;
            OP_NOT:  alu_sel_c = ALU_NOT_MASK;
            OP_NOP:  alu_sel_c = ALU_TRANSFER;
            default: alu_sel_c = ALU_TRANSFER;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle read / ALU / write-back sequencer with registered outputs.
// Optional RAM wait states enabled by defining EXEC_SEQ_RAM_WAIT_EN.
module exec_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    exec_sequencer_if.master bus
);

    localparam int unsigned INSTR_W = OPC_W + ADDR_W + DATA_W;

    seq_state_e        state_q, state_d;
    opcode_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              csn_q, csn_d;
    logic              rwn_q, rwn_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              alu_en_q, alu_en_d;
    alu_sel_e          alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;

    alu_sel_e          map_sel;
    logic              ram_cmpl;

`ifdef EXEC_SEQ_RAM_WAIT_EN
    assign ram_cmpl = bus.ram_ack;
`else
    assign ram_cmpl = 1'b1;
`endif

    seq_alu_map u_alu_map (
        .opcode    (op_d),
        .alu_sel_c (map_sel)
    );

    // Next state, latched fields, and the output values for the coming cycle
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        imm_d   = imm_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    op_d    = opcode_e'(bus.instr[INSTR_W-1 -: OPC_W]);
                    addr_d  = ADDR_W'(bus.instr[INSTR_W-OPC_W-1 -: ADDR_W]);
                    imm_d   = DATA_W'(bus.instr[DATA_W-1:0]);
                    state_d = is_nop(op_d) ? ST_IDLE : ST_READ;
                    done_d  = is_nop(op_d);
                end
            end
            ST_READ: begin
                if (ram_cmpl) begin
                    opnd_d  = bus.ram_data_out;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = bus.alu_result;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (ram_cmpl) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        csn_d     = RAM_IDLE;
        rwn_d     = RAM_READ;
        raddr_d   = '0;
        wdata_d   = '0;
        alu_en_d  = 1'b0;
        alu_sel_d = ALU_TRANSFER;
        alu_a_d   = '0;
        alu_b_d   = '0;
        ready_d   = (state_d == ST_IDLE);

        unique case (state_d)
            ST_READ: begin
                csn_d   = RAM_ACTIVE;
                rwn_d   = RAM_READ;
                raddr_d = addr_d;
            end
            ST_EXEC: begin
                alu_en_d  = 1'b1;
                alu_sel_d = map_sel;
                alu_a_d   = (op_d == OP_STO) ? '0 : opnd_d;
                alu_b_d   = imm_d;
            end
            ST_WRITE: begin
                csn_d   = RAM_ACTIVE;
                rwn_d   = RAM_WRITE;
                raddr_d = addr_d;
                wdata_d = res_d;
            end
            default: ;
        endcase
    end

    // State, latched fields and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_STO;
            addr_q    <= '0;
            imm_q     <= '0;
            opnd_q    <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            csn_q     <= RAM_IDLE;
            rwn_q     <= RAM_READ;
            raddr_q   <= '0;
            wdata_q   <= '0;
            alu_en_q  <= 1'b0;
            alu_sel_q <= ALU_TRANSFER;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            imm_q     <= imm_d;
            opnd_q    <= opnd_d;
            res_q     <= res_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            csn_q     <= csn_d;
            rwn_q     <= rwn_d;
            raddr_q   <= raddr_d;
            wdata_q   <= wdata_d;
            alu_en_q  <= alu_en_d;
            alu_sel_q <= alu_sel_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.done        = done_q;
    assign bus.ram_csn     = csn_q;
    assign bus.ram_rwn     = rwn_q;
    assign bus.ram_addr    = raddr_q;
    assign bus.ram_data_in = wdata_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_sel     = alu_sel_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: RAM/ALU models, vector table, corner sequences
// and randomized instructions against an opcode-level memory model.
module tb_exec_sequencer;
    import cpu_seq_pkg::*;

    localparam int unsigned DW  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned IW  = 3 + AW + DW;
    localparam time         TCK = 10;
`ifdef EXEC_SEQ_RAM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #(TCK/2) clk = ~clk;

    exec_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    exec_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM model: combinational read, write on the clock edge when the access completes
    logic [DW-1:0] mem [16];
    logic [DW-1:0] mem_ref [16];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic          ack_eff;

    assign ack_eff          = WAIT_EN ? bus.ram_ack : 1'b1;
    assign bus.ram_data_out = mem[bus.ram_addr];

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (!bus.ram_csn && !bus.ram_rwn && ack_eff)
            mem[bus.ram_addr] <= bus.ram_data_in;
    end

    function automatic logic [DW-1:0] alu_model(logic [3:0] sel, logic [DW-1:0] a, logic [DW-1:0] b);
        case (sel)
            ALU_ADD_AB:    return DW'(a + b);
            ALU_SUB_A_B_1: return DW'(a - b - 1'b1);
            ALU_AND_MASK:  return a & b;
            ALU_OR_MASK:   return a | b;
            ALU_XOR_MASK:  return a ^ b;
            ALU_NOT_MASK:  return ~a;
            default:       return a;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_sel, bus.alu_a, bus.alu_b);

    // Opcode-level meaning of an instruction on memory word m
    function automatic logic [DW-1:0] ref_op(logic [2:0] op, logic [DW-1:0] m, logic [DW-1:0] imm);
        case (op)
            3'd0:    return imm;
            3'd1:    return DW'(m + imm);
            3'd2:    return DW'(m - imm - 1'b1);
            3'd3:    return m & imm;
            3'd4:    return m | imm;
            3'd5:    return m ^ imm;
            3'd6:    return ~m;
            default: return m;
        endcase
    endfunction

    function automatic logic [3:0] exp_sel(logic [2:0] op);
        case (op)
            3'd0, 3'd1: return ALU_ADD_AB;
            3'd2:       return ALU_SUB_A_B_1;
            3'd3:       return ALU_AND_MASK;
            3'd4:       return ALU_OR_MASK;
            3'd5:       return ALU_XOR_MASK;
            3'd6:       return ALU_NOT_MASK;
            default:    return ALU_TRANSFER;
        endcase
    endfunction

    int  n_cmp = 0;
    int  n_bad = 0;
    time t_acc = 0;
    time t_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_defaults(input string name);
        check(name,
              32'({bus.instr_ready, bus.done, bus.ram_csn, bus.ram_rwn, bus.ram_addr,
                   bus.ram_data_in, bus.alu_en, bus.alu_sel, bus.alu_a, bus.alu_b}),
              32'({1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 4'(ALU_TRANSFER), 4'h0, 4'h0}));
    endtask

    // Called and returns at a falling edge
    task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
        mem_ref[a] = d;
    endtask

    // Issue one instruction at a falling edge and follow it to its done pulse
    task automatic run_instr(input string name, input logic [2:0] op, input logic [AW-1:0] addr,
                             input logic [DW-1:0] imm, input logic [DW-1:0] exp_val,
                             input int rd_wait, input int wr_wait);
        int lat = 0, n_alu = 0, n_rd = 0, n_wr = 0, rd_cnt = 0, wr_cnt = 0;
        int exp_lat, exp_rd, exp_wr;
        logic [DW-1:0] exp_a;
        exp_a   = (op == 3'd0) ? '0 : mem_ref[addr];
        exp_rd  = 1 + (WAIT_EN ? rd_wait : 0);
        exp_wr  = 1 + (WAIT_EN ? wr_wait : 0);
        exp_lat = (op == 3'd7) ? 1 : 2 + exp_rd + exp_wr;
        check({name, " ready"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = {op, addr, imm};
        @(posedge clk);
        t_acc = $time;
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = IW'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.alu_en) begin
                n_alu++;
                check({name, " alu_a"},   32'(bus.alu_a),   32'(exp_a));
                check({name, " alu_b"},   32'(bus.alu_b),   32'(imm));
                check({name, " alu_sel"}, 32'(bus.alu_sel), 32'(exp_sel(op)));
            end
            bus.ram_ack = WAIT_EN ? 1'b1 : 1'($urandom);
            if (!bus.ram_csn && bus.ram_rwn) begin
                n_rd++;
                check({name, " rd_addr"}, 32'(bus.ram_addr), 32'(addr));
                if (WAIT_EN && rd_cnt < rd_wait) begin
                    bus.ram_ack = 1'b0;
                    rd_cnt++;
                end
            end else if (!bus.ram_csn) begin
                n_wr++;
                check({name, " wr_bus"}, 32'({bus.ram_addr, bus.ram_data_in}), 32'({addr, exp_val}));
                if (WAIT_EN && wr_cnt < wr_wait) begin
                    bus.ram_ack = 1'b0;
                    wr_cnt++;
                end
            end
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        bus.ram_ack = 1'b1;
        check({name, " done_latency"}, 32'(lat), 32'(exp_lat));
        if (op != 3'd7) begin
            check({name, " ram_value"}, 32'(mem[addr]), 32'(exp_val));
            check({name, " access_cycles"}, 32'({8'(n_alu), 8'(n_rd), 8'(n_wr)}),
                  32'({8'd1, 8'(exp_rd), 8'(exp_wr)}));
        end else begin
            check({name, " nop_quiet"}, 32'(n_alu + n_rd + n_wr), 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] imm;
        bit            do_pre;
        logic [DW-1:0] init;
        logic [DW-1:0] exp_val;
        int            gap;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{3'd1, 4'h3, 4'h2, 1'b1, 4'h5, 4'h7, 0};
        vecs[1]  = '{3'd1, 4'h9, 4'h3, 1'b1, 4'hE, 4'h1, 0};
        vecs[2]  = '{3'd0, 4'h9, 4'hA, 1'b0, 4'h0, 4'hA, 4};
        vecs[3]  = '{3'd7, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4};
        vecs[4]  = '{3'd2, 4'h9, 4'h3, 1'b0, 4'h0, 4'h6, 1};
        vecs[5]  = '{3'd3, 4'h9, 4'hC, 1'b0, 4'h0, 4'h4, 4};
        vecs[6]  = '{3'd4, 4'h9, 4'h9, 1'b0, 4'h0, 4'hD, 4};
        vecs[7]  = '{3'd5, 4'h9, 4'hF, 1'b0, 4'h0, 4'h2, 4};
        vecs[8]  = '{3'd6, 4'h9, 4'h0, 1'b0, 4'h0, 4'hD, 4};
        vecs[9]  = '{3'd0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 4};
        vecs[10] = '{3'd1, 4'hF, 4'hF, 1'b0, 4'h0, 4'hF, 4};
        vecs[11] = '{3'd1, 4'hF, 4'h1, 1'b0, 4'h0, 4'h0, 4};

        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ram_ack     = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_defaults("in_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_defaults($sformatf("idle_after_reset_%0d", i));
        end
        for (int a = 0; a < 16; a++) preset(AW'(a), '0);

        // Vector table; consecutive entries are issued back-to-back
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_pre) preset(vecs[i].addr, vecs[i].init);
            t_prev = t_acc;
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].imm,
                      vecs[i].exp_val, 0, 0);
            if (vecs[i].op != 3'd7) mem_ref[vecs[i].addr] = vecs[i].exp_val;
            if (vecs[i].gap != 0)
                check($sformatf("vec%0d accept_gap", i), 32'((t_acc - t_prev) / TCK), 32'(vecs[i].gap));
        end

`ifdef EXEC_SEQ_RAM_WAIT_EN
        preset(4'h4, 4'h6);
        run_instr("wait_add", 3'd1, 4'h4, 4'h5, 4'hB, 3, 2);
        mem_ref[4] = 4'hB;
`endif

        // Reset while an ADD is in EXEC
        begin
            bit seen = 1'b0;
            preset(4'h5, 4'h4);
            bus.instr_valid = 1'b1;
            bus.instr       = {3'd1, 4'h5, 4'h1};
            @(posedge clk);
            #1 bus.instr_valid = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (bus.alu_en) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("reset_exec reached_exec", 32'(seen), 32'd1);
            reset_n = 1'b0;
            #1 check_defaults("reset_exec immediate");
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 2) reset_n = 1'b1;
                check($sformatf("reset_exec no_done_%0d", c), 32'(bus.done), 32'd0);
            end
            check("reset_exec no_write", 32'(mem[5]), 32'h4);
            run_instr("after_reset", 3'd1, 4'h5, 4'h2, 4'h6, 0, 0);
            mem_ref[5] = 4'h6;
        end

        // Randomized instructions against the opcode-level model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]    op;
            logic [AW-1:0] a;
            logic [DW-1:0] imm, ev;
            op  = 3'($urandom_range(0, 7));
            a   = AW'($urandom);
            imm = DW'($urandom);
            ev  = ref_op(op, mem_ref[a], imm);
            run_instr($sformatf("rnd%0d", i), op, a, imm, ev,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if (op != 3'd7) mem_ref[a] = ev;
        end
        for (int a = 0; a < 16; a++)
            check($sformatf("final_mem_%0d", a), 32'(mem[a]), 32'(mem_ref[a]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
